// File: rtl/stage_exe_if.sv
// Execute-stage types and the bundle carrying decoded control/operands in and results out.
// Latency: none; the interface holds wires only.
// Backpressure: stall is carried as exe_o_stallreq; there is no per-signal handshake.
package stage_exe_pkg;

   typedef enum logic [2:0] {
      ALU_NOP   = 3'd0,
      ALU_ARITH = 3'd1,
      ALU_LOGIC = 3'd2,
      ALU_MOVE  = 3'd3,
      ALU_SHIFT = 3'd4
   } alutype_enum;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_LT   = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOR  = 4'd7,
      OP_LL   = 4'd8,
      OP_RL   = 4'd9,
      OP_RA   = 4'd10,
      OP_HI   = 4'd11,
      OP_LO   = 4'd12,
      OP_MULT = 4'd13,
      OP_DIV  = 4'd14
   } aluop_code_enum;

   typedef struct packed {
      logic           sign;
      aluop_code_enum code;
   } aluop_struct;

   typedef struct packed {
      logic       load;
      logic       store;
      logic [1:0] size;
      logic       sext;
   } memop_struct;

endpackage

interface stage_exe_if;
   import stage_exe_pkg::*;

   alutype_enum  exe_i_alutype;
   aluop_struct  exe_i_aluop;
   logic [31:0]  exe_i_src1;
   logic [31:0]  exe_i_src2;
   logic         exe_i_rfwe;
   logic [4:0]   exe_i_rfwa;
   logic         exe_i_hilowe;
   logic         exe_i_dm2rf;
   memop_struct  exe_i_memop;
   logic [31:0]  exe_i_dmdin;
   logic [31:0]  exe_i_hi;
   logic [31:0]  exe_i_lo;
   logic         exe_i_flush;

   logic [31:0]  exe_o_alures;
   logic [63:0]  exe_o_hilo;
   logic         exe_o_rfwe;
   logic [4:0]   exe_o_rfwa;
   logic         exe_o_hilowe;
   logic         exe_o_dm2rf;
   memop_struct  exe_o_memop;
   logic [31:0]  exe_o_dmdin;
   logic         exe_o_stallreq;

   // Upstream register / testbench side: drives control and operands, observes results.
   modport master (
      output exe_i_alutype, exe_i_aluop, exe_i_src1, exe_i_src2, exe_i_rfwe, exe_i_rfwa,
             exe_i_hilowe, exe_i_dm2rf, exe_i_memop, exe_i_dmdin, exe_i_hi, exe_i_lo, exe_i_flush,
      input  exe_o_alures, exe_o_hilo, exe_o_rfwe, exe_o_rfwa, exe_o_hilowe, exe_o_dm2rf,
             exe_o_memop, exe_o_dmdin, exe_o_stallreq
   );

   // Execute stage side.
   modport slave (
      input  exe_i_alutype, exe_i_aluop, exe_i_src1, exe_i_src2, exe_i_rfwe, exe_i_rfwa,
             exe_i_hilowe, exe_i_dm2rf, exe_i_memop, exe_i_dmdin, exe_i_hi, exe_i_lo, exe_i_flush,
      output exe_o_alures, exe_o_hilo, exe_o_rfwe, exe_o_rfwa, exe_o_hilowe, exe_o_dm2rf,
             exe_o_memop, exe_o_dmdin, exe_o_stallreq
   );

endinterface

// File: rtl/stage_exe.sv
// Execute stage: ALU, 64-bit multiply, iterative radix-2 restoring divide, store-path pass-through.
// Latency: combinational for everything except DIV (DIV_CYCLES+1 stall cycles, 1 for divide by zero).
// Backpressure: raises exe_o_stallreq while a divide runs; upstream holds its inputs frozen meanwhile.
module stage_exe
   import stage_exe_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic       cpu_clk_50M,
   input  logic       cpu_rst_n,
   stage_exe_if.slave exe
);

   localparam int             CW       = $clog2(DIV_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DIV_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } div_state_e;

   div_state_e    state;
   div_state_e    state_nxt;
   logic          div_start;
   logic          div_step;
   logic          stall;

   logic [CW-1:0] cnt;
   logic [31:0]   rem_q;
   logic [31:0]   quo_q;
   logic [31:0]   dvs_q;
   logic          q_neg;
   logic          r_neg;

   logic          is_div;
   logic          is_mult;
   logic          sgn;
   logic          div_zero;
   logic          a_neg;
   logic          b_neg;
   logic [31:0]   a_abs;
   logic [31:0]   b_abs;

   logic [32:0]   trial_shift;
   logic [32:0]   trial_diff;
   logic [31:0]   div_hi;
   logic [31:0]   div_lo;
   logic [63:0]   mul_a;
   logic [63:0]   mul_b;
   logic [63:0]   mul_prod;

   assign sgn      = exe.exe_i_aluop.sign;
   assign is_div   = (exe.exe_i_alutype == ALU_NOP) && (exe.exe_i_aluop.code == OP_DIV);
   assign is_mult  = (exe.exe_i_alutype == ALU_NOP) && (exe.exe_i_aluop.code == OP_MULT);
   assign div_zero = (exe.exe_i_src2 == 32'd0);

   // Magnitudes are only taken for signed divides; unsigned operands pass through unchanged.
   assign a_neg = sgn & exe.exe_i_src1[31];
   assign b_neg = sgn & exe.exe_i_src2[31];
   assign a_abs = a_neg ? (~exe.exe_i_src1 + 32'd1) : exe.exe_i_src1;
   assign b_abs = b_neg ? (~exe.exe_i_src2 + 32'd1) : exe.exe_i_src2;

   // One restoring step: shift the next dividend bit into the partial remainder and try a subtract.
   assign trial_shift = {rem_q, quo_q[31]};
   assign trial_diff  = trial_shift - {1'b0, dvs_q};

   // Sign correction happens on the way out so the iteration itself stays unsigned.
   assign div_lo = q_neg ? (~quo_q + 32'd1) : quo_q;
   assign div_hi = r_neg ? (~rem_q + 32'd1) : rem_q;

   // Sign-extending to 64 bits makes the low 64 product bits correct for both signed and unsigned.
   assign mul_a    = {{32{sgn & exe.exe_i_src1[31]}}, exe.exe_i_src1};
   assign mul_b    = {{32{sgn & exe.exe_i_src2[31]}}, exe.exe_i_src2};
   assign mul_prod = mul_a * mul_b;

   // Divider state register.
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Divider next state and stall request; a flush always wins and lands in IDLE.
   always_comb begin
      state_nxt = state;
      div_start = 1'b0;
      div_step  = 1'b0;
      stall     = 1'b0;
      case (state)
         S_IDLE: begin
            if (is_div && !exe.exe_i_flush) begin
               div_start = 1'b1;
               stall     = 1'b1;
               state_nxt = div_zero ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            div_step = 1'b1;
            stall    = 1'b1;
            if (cnt == CNT_LAST) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (exe.exe_i_flush) begin
         state_nxt = S_IDLE;
      end
   end

   // Divider datapath: latch operands on start, then one quotient bit per BUSY cycle.
   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         cnt   <= '0;
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (div_start) begin
         cnt <= '0;
         if (div_zero) begin
            // Divide by zero skips iteration; results are preloaded raw with no sign fix-up.
            quo_q <= 32'hFFFF_FFFF;
            rem_q <= exe.exe_i_src1;
            dvs_q <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
         end else begin
            quo_q <= a_abs;
            rem_q <= '0;
            dvs_q <= b_abs;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
         end
      end else if (div_step) begin
         cnt <= cnt + CW'(1);
         if (trial_diff[32]) begin
            rem_q <= trial_shift[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
         end else begin
            rem_q <= trial_diff[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
         end
      end
   end

   // ALU result, selected by operation class then sub-operation.
   always_comb begin
      exe.exe_o_alures = 32'd0;
      case (exe.exe_i_alutype)
         ALU_ARITH: begin
            case (exe.exe_i_aluop.code)
               OP_ADD:  exe.exe_o_alures = exe.exe_i_src1 + exe.exe_i_src2;
               OP_SUB:  exe.exe_o_alures = exe.exe_i_src1 - exe.exe_i_src2;
               OP_LT: begin
                  if (sgn) begin
                     exe.exe_o_alures = {31'd0, $signed(exe.exe_i_src1) < $signed(exe.exe_i_src2)};
                  end else begin
                     exe.exe_o_alures = {31'd0, exe.exe_i_src1 < exe.exe_i_src2};
                  end
               end
               default: exe.exe_o_alures = 32'd0;
            endcase
         end
         ALU_LOGIC: begin
            case (exe.exe_i_aluop.code)
               OP_AND:  exe.exe_o_alures = exe.exe_i_src1 & exe.exe_i_src2;
               OP_OR:   exe.exe_o_alures = exe.exe_i_src1 | exe.exe_i_src2;
               OP_XOR:  exe.exe_o_alures = exe.exe_i_src1 ^ exe.exe_i_src2;
               OP_NOR:  exe.exe_o_alures = ~(exe.exe_i_src1 | exe.exe_i_src2);
               default: exe.exe_o_alures = 32'd0;
            endcase
         end
         ALU_SHIFT: begin
            case (exe.exe_i_aluop.code)
               OP_LL:   exe.exe_o_alures = exe.exe_i_src2 << exe.exe_i_src1[4:0];
               OP_RL:   exe.exe_o_alures = exe.exe_i_src2 >> exe.exe_i_src1[4:0];
               OP_RA:   exe.exe_o_alures = $signed(exe.exe_i_src2) >>> exe.exe_i_src1[4:0];
               default: exe.exe_o_alures = 32'd0;
            endcase
         end
         ALU_MOVE: begin
            case (exe.exe_i_aluop.code)
               OP_HI:   exe.exe_o_alures = exe.exe_i_hi;
               OP_LO:   exe.exe_o_alures = exe.exe_i_lo;
               default: exe.exe_o_alures = 32'd0;
            endcase
         end
         default: exe.exe_o_alures = 32'd0;
      endcase
   end

   // HI/LO result: divide result only in its DONE cycle, otherwise the product for MULT.
   always_comb begin
      exe.exe_o_hilo = 64'd0;
      if (state == S_DONE) begin
         exe.exe_o_hilo = {div_hi, div_lo};
      end else if (is_mult) begin
         exe.exe_o_hilo = mul_prod;
      end
   end

   assign exe.exe_o_stallreq = stall & cpu_rst_n;

   assign exe.exe_o_rfwe   = exe.exe_i_rfwe;
   assign exe.exe_o_rfwa   = exe.exe_i_rfwa;
   assign exe.exe_o_hilowe = exe.exe_i_hilowe;
   assign exe.exe_o_dm2rf  = exe.exe_i_dm2rf;
   assign exe.exe_o_memop  = exe.exe_i_memop;
   assign exe.exe_o_dmdin  = exe.exe_i_dmdin;

endmodule

// File: tb/tb_stage_exe.sv
// Bench for stage_exe: directed corner cases plus randomized ALU/MULT/DIV against an arithmetic model.
module tb_stage_exe;
   import stage_exe_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   stage_exe_if bus();

   stage_exe #(.DIV_CYCLES(32)) dut (
      .cpu_clk_50M (clk),
      .cpu_rst_n   (rst_n),
      .exe         (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input alutype_enum t, input logic sg, input aluop_code_enum c,
                        input logic [31:0] a, input logic [31:0] b);
      aluop_struct op;
      op.sign = sg;
      op.code = c;
      bus.exe_i_alutype = t;
      bus.exe_i_aluop   = op;
      bus.exe_i_src1    = a;
      bus.exe_i_src2    = b;
   endtask

   // Reference: plain arithmetic on the operation's meaning.
   function automatic logic [95:0] alu_model(input alutype_enum t, input logic sg, input aluop_code_enum c,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] hi, input logic [31:0] lo);
      logic [31:0] r;
      logic [63:0] hl;
      int          sh;
      longint      sa;
      longint      sb;
      r  = 32'd0;
      hl = 64'd0;
      sh = int'(a % 32);
      if (t == ALU_ARITH) begin
         if (c == OP_ADD) r = a + b;
         if (c == OP_SUB) r = a - b;
         if (c == OP_LT) begin
            sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
            sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
            r  = (sa < sb) ? 32'd1 : 32'd0;
         end
      end else if (t == ALU_LOGIC) begin
         if (c == OP_AND) r = a & b;
         if (c == OP_OR)  r = a | b;
         if (c == OP_XOR) r = a ^ b;
         if (c == OP_NOR) r = ~(a | b);
      end else if (t == ALU_SHIFT) begin
         if (c == OP_LL) r = b << sh;
         if (c == OP_RL) r = b >> sh;
         if (c == OP_RA) r = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      end else if (t == ALU_MOVE) begin
         if (c == OP_HI) r = hi;
         if (c == OP_LO) r = lo;
      end else if (t == ALU_NOP && c == OP_MULT) begin
         if (sg) hl = longint'($signed(a)) * longint'($signed(b));
         else    hl = {32'd0, a} * {32'd0, b};
      end
      return {hl, r};
   endfunction

   function automatic logic [63:0] div_model(input logic sg, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint rm;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
      q  = sa / sb;
      rm = sa % sb;
      return {rm[31:0], q[31:0]};
   endfunction

   task automatic alu_case(input string tag, input alutype_enum t, input logic sg, input aluop_code_enum c,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [63:0] ehl);
      @(posedge clk); #1;
      drive(t, sg, c, a, b);
      @(negedge clk);
      check({tag, "_res"},   {32'd0, bus.exe_o_alures}, {32'd0, er});
      check({tag, "_hilo"},  bus.exe_o_hilo, ehl);
      check({tag, "_stall"}, {63'd0, bus.exe_o_stallreq}, 64'd0);
   endtask

   // Presents a DIV, counts stall cycles (bounded) and checks the result in the cycle stall falls.
   task automatic div_case(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input int exp_stalls, input logic [63:0] exp_hl);
      int n;
      @(posedge clk); #1;
      drive(ALU_NOP, sg, OP_DIV, a, b);
      n = 0;
      @(negedge clk);
      while (bus.exe_o_stallreq === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_stalls"}, 64'(n), 64'(exp_stalls));
      check({tag, "_hilo"}, bus.exe_o_hilo, exp_hl);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [95:0]    m;
      alutype_enum    t;
      aluop_code_enum c;
      logic           sg;
      logic [31:0]    a;
      logic [31:0]    b;
      logic [44:0]    pt;
      memop_struct    mo;
      n_chk  = 0;
      n_pass = 0;

      rst_n = 1'b0;
      bus.exe_i_flush  = 1'b0;
      bus.exe_i_rfwe   = 1'b0;
      bus.exe_i_rfwa   = 5'd0;
      bus.exe_i_hilowe = 1'b0;
      bus.exe_i_dm2rf  = 1'b0;
      bus.exe_i_memop  = '0;
      bus.exe_i_dmdin  = 32'd0;
      bus.exe_i_hi     = 32'd0;
      bus.exe_i_lo     = 32'd0;
      drive(ALU_NOP, 1'b0, OP_DIV, 32'd100, 32'd7);
      #25;
      check("rst_stall_div", {63'd0, bus.exe_o_stallreq}, 64'd0);
      drive(ALU_NOP, 1'b0, OP_NONE, 32'h1234, 32'h5678);
      #1;
      check("rst_res",  {32'd0, bus.exe_o_alures}, 64'd0);
      check("rst_hilo", bus.exe_o_hilo, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_stall", {63'd0, bus.exe_o_stallreq}, 64'd0);

      alu_case("add_wrap", ALU_ARITH, 1'b0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 64'd0);
      alu_case("slt_s",    ALU_ARITH, 1'b1, OP_LT,  32'hFFFF_FFFF, 32'd1, 32'd1, 64'd0);
      alu_case("slt_u",    ALU_ARITH, 1'b0, OP_LT,  32'hFFFF_FFFF, 32'd1, 32'd0, 64'd0);
      alu_case("sra",      ALU_SHIFT, 1'b0, OP_RA,  32'd4,  32'h8000_0000, 32'hF800_0000, 64'd0);
      alu_case("sll",      ALU_SHIFT, 1'b0, OP_LL,  32'd31, 32'd3, 32'h8000_0000, 64'd0);
      alu_case("mult_s",   ALU_NOP,   1'b1, OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'd0, 64'hFFFF_FFFF_FFFF_FFEB);
      alu_case("mult_u",   ALU_NOP,   1'b0, OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
               64'hFFFF_FFFE_0000_0001);

      div_case("div_s",    1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      div_case("div_u",    1'b0, 32'd100, 32'd7, 33, {32'd2, 32'd14});
      div_case("div_zero", 1'b1, 32'h8000_0005, 32'd0, 1, {32'h8000_0005, 32'hFFFF_FFFF});
      div_case("div_ovf",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'd0, 32'h8000_0000});

      // Flush in BUSY cycle 10: stall must drop on the following cycle.
      @(posedge clk); #1;
      drive(ALU_NOP, 1'b0, OP_DIV, 32'd1000, 32'd3);
      repeat (11) @(posedge clk);
      #1;
      bus.exe_i_flush = 1'b1;
      @(negedge clk);
      check("flush_busy_stall", {63'd0, bus.exe_o_stallreq}, 64'd1);
      @(posedge clk); #1;
      bus.exe_i_flush = 1'b0;
      drive(ALU_NOP, 1'b0, OP_NONE, 32'd0, 32'd0);
      @(negedge clk);
      check("flush_after_stall", {63'd0, bus.exe_o_stallreq}, 64'd0);
      div_case("div_post_flush", 1'b0, 32'd1000, 32'd3, 33, {32'd1, 32'd333});

      // Reset pulsed mid-divide, then a fresh divide must run its full length.
      @(posedge clk); #1;
      drive(ALU_NOP, 1'b1, OP_DIV, 32'hFFFF_FF9C, 32'd9);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(ALU_NOP, 1'b0, OP_NONE, 32'd0, 32'd0);
      #1;
      check("rst_mid_stall", {63'd0, bus.exe_o_stallreq}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      div_case("div_post_rst", 1'b1, 32'hFFFF_FF9C, 32'd9, 33, {32'hFFFF_FFFF, 32'hFFFF_FFF5});

      // Randomized single-cycle operations with random pass-through fields.
      for (int i = 0; i < 150; i++) begin
         t = alutype_enum'($urandom_range(0, 4));
         case (t)
            ALU_ARITH: c = aluop_code_enum'($urandom_range(1, 3));
            ALU_LOGIC: c = aluop_code_enum'($urandom_range(4, 7));
            ALU_SHIFT: c = aluop_code_enum'($urandom_range(8, 10));
            ALU_MOVE:  c = aluop_code_enum'($urandom_range(11, 12));
            default:   c = ($urandom_range(0, 1) == 1) ? OP_MULT : OP_NONE;
         endcase
         sg = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         @(posedge clk); #1;
         drive(t, sg, c, a, b);
         bus.exe_i_hi     = $urandom;
         bus.exe_i_lo     = $urandom;
         bus.exe_i_rfwe   = 1'($urandom_range(0, 1));
         bus.exe_i_rfwa   = 5'($urandom_range(0, 31));
         bus.exe_i_hilowe = 1'($urandom_range(0, 1));
         bus.exe_i_dm2rf  = 1'($urandom_range(0, 1));
         mo               = memop_struct'(5'($urandom_range(0, 31)));
         bus.exe_i_memop  = mo;
         bus.exe_i_dmdin  = $urandom;
         m  = alu_model(t, sg, c, a, b, bus.exe_i_hi, bus.exe_i_lo);
         pt = {bus.exe_i_rfwe, bus.exe_i_rfwa, bus.exe_i_hilowe, bus.exe_i_dm2rf, mo, bus.exe_i_dmdin};
         @(negedge clk);
         check("rnd_res",   {32'd0, bus.exe_o_alures}, {32'd0, m[31:0]});
         check("rnd_hilo",  bus.exe_o_hilo, m[95:32]);
         check("rnd_stall", {63'd0, bus.exe_o_stallreq}, 64'd0);
         check("rnd_pass",  {19'd0, bus.exe_o_rfwe, bus.exe_o_rfwa, bus.exe_o_hilowe, bus.exe_o_dm2rf,
                             bus.exe_o_memop, bus.exe_o_dmdin}, {19'd0, pt});
      end

      // Randomized back-to-back divides, including zero and small divisors.
      for (int i = 0; i < 12; i++) begin
         sg = 1'($urandom_range(0, 1));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 20));
            2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            default: b = $urandom;
         endcase
         div_case("rnd_div", sg, a, b, (b == 32'd0) ? 1 : 33, div_model(sg, a, b));
      end

      @(posedge clk); #1;
      drive(ALU_NOP, 1'b0, OP_NONE, 32'd0, 32'd0);
      @(negedge clk);
      check("end_idle_stall", {63'd0, bus.exe_o_stallreq}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
